// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock synchronous FIFO, depth 2^A_SIZE words of D_SIZE bits, with
//   occupancy level, programmable almost-full/almost-empty thresholds and
//   sticky overflow/underflow error flags.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   : first-word fall-through, R_DATA = mem[rptr] whenever not empty
//   undefined : R_DATA is registered and loaded on the edge that accepts a read
//
// Ports
//   CLK          in   clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   W_INC        in   write request
//   W_DATA       in   write data (D_SIZE)
//   FULL         out  LEVEL == 2^A_SIZE
//   ALMOST_FULL  out  LEVEL >= AF_LEVEL
//   R_INC        in   read request
//   R_DATA       out  read data (D_SIZE)
//   EMPTY        out  LEVEL == 0
//   ALMOST_EMPTY out  LEVEL <= AE_LEVEL
//   LEVEL        out  occupancy 0..2^A_SIZE (A_SIZE+1 bits)
//   OVERFLOW     out  sticky: write attempted while full
//   UNDERFLOW    out  sticky: read attempted while empty
//   CLR_ERR      in   synchronous clear of OVERFLOW/UNDERFLOW (set wins)
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int D_SIZE   = 8,
   parameter int A_SIZE   = 4,
   parameter int AF_LEVEL = (1 << A_SIZE) - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              W_INC,
   input  logic [D_SIZE-1:0] W_DATA,
   output logic              FULL,
   output logic              ALMOST_FULL,
   input  logic              R_INC,
   output logic [D_SIZE-1:0] R_DATA,
   output logic              EMPTY,
   output logic              ALMOST_EMPTY,
   output logic [A_SIZE:0]   LEVEL,
   output logic              OVERFLOW,
   output logic              UNDERFLOW,
   input  logic              CLR_ERR
);

   localparam int              DEPTH   = 1 << A_SIZE;
   localparam logic [A_SIZE:0] DEPTH_L = (A_SIZE+1)'(DEPTH);
   localparam logic [A_SIZE:0] ONE_L   = (A_SIZE+1)'(1);
   localparam logic [A_SIZE:0] AF_L    = (A_SIZE+1)'(AF_LEVEL);
   localparam logic [A_SIZE:0] AE_L    = (A_SIZE+1)'(AE_LEVEL);
   // A zero threshold means "always almost full", including out of reset.
   localparam logic            AF_RST  = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

   logic [D_SIZE-1:0] mem_r [DEPTH];

   logic [A_SIZE:0] wptr_r;
   logic [A_SIZE:0] rptr_r;
   logic [A_SIZE:0] level_r;
   logic            full_r;
   logic            empty_r;
   logic            afull_r;
   logic            aempty_r;
   logic            ovf_r;
   logic            unf_r;

   logic            w_acc_s;
   logic            r_acc_s;
   logic [A_SIZE:0] wptr_nxt_s;
   logic [A_SIZE:0] rptr_nxt_s;
   logic [A_SIZE:0] level_nxt_s;

   // Accept decisions and next pointer/level values from the registered flags.
   always_comb begin
      w_acc_s = W_INC & ~full_r;
      r_acc_s = R_INC & ~empty_r;
      if (w_acc_s) begin
         wptr_nxt_s = wptr_r + ONE_L;
      end else begin
         wptr_nxt_s = wptr_r;
      end
      if (r_acc_s) begin
         rptr_nxt_s = rptr_r + ONE_L;
      end else begin
         rptr_nxt_s = rptr_r;
      end
      // Modulo 2^(A_SIZE+1) difference; the extra MSB separates full from empty.
      level_nxt_s = wptr_nxt_s - rptr_nxt_s;
   end

   // Pointers, level and status flags; flags are computed from the next level
   // so they are registered yet valid right after the update edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr_r   <= '0;
         rptr_r   <= '0;
         level_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         afull_r  <= AF_RST;
         aempty_r <= 1'b1;
      end else begin
         wptr_r   <= wptr_nxt_s;
         rptr_r   <= rptr_nxt_s;
         level_r  <= level_nxt_s;
         full_r   <= (level_nxt_s == DEPTH_L);
         empty_r  <= (level_nxt_s == '0);
         afull_r  <= (level_nxt_s >= AF_L);
         aempty_r <= (level_nxt_s <= AE_L);
      end
   end

   // Sticky error flags; a new error event in the same cycle beats CLR_ERR.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (W_INC && full_r) begin
            ovf_r <= 1'b1;
         end else if (CLR_ERR) begin
            ovf_r <= 1'b0;
         end
         if (R_INC && empty_r) begin
            unf_r <= 1'b1;
         end else if (CLR_ERR) begin
            unf_r <= 1'b0;
         end
      end
   end

   // Storage array; intentionally not reset, writes are blocked while in reset.
   always_ff @(posedge CLK) begin
      if (w_acc_s && RST_N) begin
         mem_r[wptr_r[A_SIZE-1:0]] <= W_DATA;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word falls through; value is meaningless while EMPTY is high.
   assign R_DATA = mem_r[rptr_r[A_SIZE-1:0]];
`else
   logic [D_SIZE-1:0] rdata_r;

   // Registered read port, holds its value unless a read is accepted.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata_r <= '0;
      end else if (r_acc_s) begin
         rdata_r <= mem_r[rptr_r[A_SIZE-1:0]];
      end
   end

   assign R_DATA = rdata_r;
`endif

   assign FULL         = full_r;
   assign EMPTY        = empty_r;
   assign ALMOST_FULL  = afull_r;
   assign ALMOST_EMPTY = aempty_r;
   assign LEVEL        = level_r;
   assign OVERFLOW     = ovf_r;
   assign UNDERFLOW    = unf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//   Directed self-checking bench for sync_fifo_flags (D_SIZE=8, A_SIZE=4,
//   AF_LEVEL=14, AE_LEVEL=2). Works in both read modes; mode-specific checks
//   are selected with SYNC_FIFO_FWFT_EN.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

   logic       clk_s;
   logic       rst_n_s;
   logic       w_inc_s;
   logic [7:0] w_data_s;
   logic       full_s;
   logic       afull_s;
   logic       r_inc_s;
   logic [7:0] r_data_s;
   logic       empty_s;
   logic       aempty_s;
   logic [4:0] level_s;
   logic       ovf_s;
   logic       unf_s;
   logic       clr_err_s;

   int checks_r;
   int errors_r;

   sync_fifo_flags #(
      .D_SIZE   (8),
      .A_SIZE   (4),
      .AF_LEVEL (14),
      .AE_LEVEL (2)
   ) dut (
      .CLK          (clk_s),
      .RST_N        (rst_n_s),
      .W_INC        (w_inc_s),
      .W_DATA       (w_data_s),
      .FULL         (full_s),
      .ALMOST_FULL  (afull_s),
      .R_INC        (r_inc_s),
      .R_DATA       (r_data_s),
      .EMPTY        (empty_s),
      .ALMOST_EMPTY (aempty_s),
      .LEVEL        (level_s),
      .OVERFLOW     (ovf_s),
      .UNDERFLOW    (unf_s),
      .CLR_ERR      (clr_err_s)
   );

   // Free-running 100 MHz clock.
   initial clk_s = 1'b0;
   always #5 clk_s = ~clk_s;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r = checks_r + 1;
      if (got !== exp) begin
         errors_r = errors_r + 1;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sampling happens 1 ns after the rising edge.
   task automatic step();
      @(posedge clk_s);
      #1;
   endtask

   // Pop one word and compare it with the expected value.
   task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      check(tag, {24'd0, r_data_s}, {24'd0, exp});
      r_inc_s = 1'b1;
      step();
      r_inc_s = 1'b0;
`else
      r_inc_s = 1'b1;
      step();
      r_inc_s = 1'b0;
      check(tag, {24'd0, r_data_s}, {24'd0, exp});
`endif
   endtask

   task automatic push(input logic [7:0] d);
      w_inc_s  = 1'b1;
      w_data_s = d;
      step();
      w_inc_s  = 1'b0;
   endtask

   task automatic clear_err();
      clr_err_s = 1'b1;
      step();
      clr_err_s = 1'b0;
   endtask

   initial begin
      checks_r  = 0;
      errors_r  = 0;
      rst_n_s   = 1'b0;
      w_inc_s   = 1'b0;
      w_data_s  = 8'h00;
      r_inc_s   = 1'b0;
      clr_err_s = 1'b0;
      step();
      step();

      // Reset state
      check("rst_level", {27'd0, level_s}, 32'd0);
      check("rst_empty", {31'd0, empty_s}, 32'd1);
      check("rst_aempty", {31'd0, aempty_s}, 32'd1);
      check("rst_full", {31'd0, full_s}, 32'd0);
      check("rst_afull", {31'd0, afull_s}, 32'd0);
      check("rst_ovf", {31'd0, ovf_s}, 32'd0);
      check("rst_unf", {31'd0, unf_s}, 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("rst_rdata", {24'd0, r_data_s}, 32'd0);
`endif
      rst_n_s = 1'b1;
      step();

      // Fill 0x00..0x0F, flags tracked against level
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         check("fill_level", {27'd0, level_s}, 32'(i + 1));
         check("fill_aempty", {31'd0, aempty_s}, 32'((i + 1) <= 2));
         check("fill_afull", {31'd0, afull_s}, 32'((i + 1) >= 14));
         check("fill_full", {31'd0, full_s}, 32'((i + 1) == 16));
         check("fill_empty", {31'd0, empty_s}, 32'd0);
      end
      check("fill_ovf", {31'd0, ovf_s}, 32'd0);

      // Overflow attempt while full
      push(8'hAA);
      check("ovf_level", {27'd0, level_s}, 32'd16);
      check("ovf_flag", {31'd0, ovf_s}, 32'd1);
      check("ovf_full", {31'd0, full_s}, 32'd1);

      // Drain in order; 0xAA must never appear
      for (int i = 0; i < 16; i++) begin
         pop_check("drain_data", 8'(i));
      end
      check("drain_empty", {31'd0, empty_s}, 32'd1);
      check("drain_level", {27'd0, level_s}, 32'd0);
      check("drain_ovf_sticky", {31'd0, ovf_s}, 32'd1);
      clear_err();
      check("ovf_cleared", {31'd0, ovf_s}, 32'd0);

      // Underflow on empty read, R_DATA held
      r_inc_s = 1'b1;
      step();
      r_inc_s = 1'b0;
      check("unf_flag", {31'd0, unf_s}, 32'd1);
      check("unf_level", {27'd0, level_s}, 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("unf_rdata_hold", {24'd0, r_data_s}, 32'h0F);
`endif
      clear_err();
      check("unf_cleared", {31'd0, unf_s}, 32'd0);
      clr_err_s = 1'b1;
      r_inc_s   = 1'b1;
      step();
      clr_err_s = 1'b0;
      r_inc_s   = 1'b0;
      check("unf_set_wins", {31'd0, unf_s}, 32'd1);
      clear_err();

      // Streaming at level 8 for 40 cycles, pointers wrap
      for (int i = 0; i < 8; i++) begin
         push(8'(8'h20 + i));
      end
      check("stream_start_level", {27'd0, level_s}, 32'd8);
      for (int i = 0; i < 40; i++) begin
         w_inc_s  = 1'b1;
         w_data_s = 8'(8'h28 + i);
`ifdef SYNC_FIFO_FWFT_EN
         check("stream_data", {24'd0, r_data_s}, 32'(8'h20 + i));
         r_inc_s = 1'b1;
         step();
`else
         r_inc_s = 1'b1;
         step();
         check("stream_data", {24'd0, r_data_s}, 32'(8'h20 + i));
`endif
         check("stream_level", {27'd0, level_s}, 32'd8);
      end
      w_inc_s = 1'b0;
      r_inc_s = 1'b0;

      // Simultaneous read+write while full: read wins, overflow set
      for (int i = 0; i < 8; i++) begin
         push(8'(8'h50 + i));
      end
      check("full2_level", {27'd0, level_s}, 32'd16);
      w_inc_s  = 1'b1;
      w_data_s = 8'hEE;
`ifdef SYNC_FIFO_FWFT_EN
      check("full_rw_data", {24'd0, r_data_s}, 32'h48);
`endif
      r_inc_s  = 1'b1;
      step();
      w_inc_s  = 1'b0;
      r_inc_s  = 1'b0;
      check("full_rw_level", {27'd0, level_s}, 32'd15);
      check("full_rw_ovf", {31'd0, ovf_s}, 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      check("full_rw_data", {24'd0, r_data_s}, 32'h48);
`endif
      for (int i = 0; i < 15; i++) begin
         pop_check("full_rw_drain", (i < 7) ? 8'(8'h49 + i) : 8'(8'h50 + i - 7));
      end
      check("full_rw_empty", {31'd0, empty_s}, 32'd1);
      clear_err();

      // Simultaneous read+write while empty: write wins, underflow set
      w_inc_s  = 1'b1;
      w_data_s = 8'h60;
      r_inc_s  = 1'b1;
      step();
      w_inc_s  = 1'b0;
      r_inc_s  = 1'b0;
      check("empty_rw_level", {27'd0, level_s}, 32'd1);
      check("empty_rw_unf", {31'd0, unf_s}, 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      check("empty_rw_nobypass", {24'd0, r_data_s}, 32'h57);
`endif
      clear_err();
      pop_check("empty_rw_data", 8'h60);

      // Write-to-read latency with 0x5A
      push(8'h5A);
      check("lat_empty", {31'd0, empty_s}, 32'd0);
      pop_check("lat_data", 8'h5A);
      check("lat_empty_after", {31'd0, empty_s}, 32'd1);

      // Asynchronous reset mid-cycle with 10 words buffered
      for (int i = 0; i < 10; i++) begin
         push(8'(8'h70 + i));
      end
      r_inc_s = 1'b1;
      step();
      r_inc_s = 1'b0;
      r_inc_s = 1'b1;
      step();
      r_inc_s = 1'b0;
      w_inc_s = 1'b1;
      w_data_s = 8'h7A;
      step();
      w_inc_s = 1'b0;
      check("pre_rst_level", {27'd0, level_s}, 32'd9);
      #2;
      rst_n_s = 1'b0;
      #1;
      check("arst_level", {27'd0, level_s}, 32'd0);
      check("arst_empty", {31'd0, empty_s}, 32'd1);
      check("arst_aempty", {31'd0, aempty_s}, 32'd1);
      check("arst_afull", {31'd0, afull_s}, 32'd0);
      check("arst_full", {31'd0, full_s}, 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check("arst_rdata", {24'd0, r_data_s}, 32'd0);
`endif
      step();
      rst_n_s = 1'b1;
      step();
      push(8'h33);
      check("post_rst_level", {27'd0, level_s}, 32'd1);
      pop_check("post_rst_data", 8'h33);
      check("post_rst_empty", {31'd0, empty_s}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
